// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register offsets within the controller's 4-byte window, and the ID width.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_ACTIVE  = 2'd2;
  localparam logic [1:0] REG_CLEAR   = 2'd3;

  localparam int ID_W = 3;

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-first priority encoder: vld is set when any request bit is
// set, and idx is the position of the lowest set bit.
module irq_priority_encoder
  import irq_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  output logic            vld,
  output logic [ID_W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped fixed-priority interrupt controller with edge capture and a
// CPU request/acknowledge handshake. Define IRQ_CTRL_TIMEOUT_EN to add the ack watchdog.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter logic [7:0] p_irq_ctrl_base_addr = 8'hE0,
  parameter int         p_num_sources        = 4,
  parameter logic [7:0] p_initial_mask       = 8'hFF,
  parameter int         p_ack_timeout        = 1000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  inout  wire  [7:0]               BUS_DATA,
  input  logic [7:0]               BUS_ADDR,
  input  logic                     BUS_WE,
  input  logic [p_num_sources-1:0] SRC_IRQ_RAISE,
  output logic [p_num_sources-1:0] SRC_IRQ_ACK,
  output logic                     CPU_IRQ,
  output logic [ID_W-1:0]          CPU_IRQ_ID,
  input  logic                     CPU_IRQ_ACK
);

  localparam int N = p_num_sources;

  logic [N-1:0]    src_prev_q, src_prev_d, pending_q, pending_d;
  logic [N-1:0]    rise, sw_clr, ack_clr, pend_sw, eligible, id_oh;
  logic [7:0]      mask_q, mask_d, rd_data_q, rd_data_d, ofs;
  logic            rd_en_q, rd_en_d, vld_q, vld_d;
  logic            enc_vld, wr_hit, rd_hit, pend_held, ack_go, timeout, tmo_flag;
  logic [ID_W-1:0] id_q, id_d, enc_idx;
  irq_state_e      state_q, state_d;

  assign ofs      = BUS_ADDR - p_irq_ctrl_base_addr;
  assign wr_hit   = BUS_WE && (ofs < 8'd4);
  assign rd_hit   = !BUS_WE && (ofs < 8'd4) && (ofs[1:0] != REG_CLEAR);
  assign eligible = pending_q & mask_q[N-1:0];

  irq_priority_encoder #(.N(N)) u_enc (
    .req (eligible),
    .vld (enc_vld),
    .idx (enc_idx)
  );

  // Pending bits: rising edges always win over same-cycle clears.
  always_comb begin
    id_oh      = N'(1) << id_q;
    src_prev_d = SRC_IRQ_RAISE;
    rise       = SRC_IRQ_RAISE & ~src_prev_q;
    sw_clr     = (wr_hit && ofs[1:0] == REG_CLEAR) ? BUS_DATA[N-1:0] : '0;
    pend_sw    = (pending_q & ~sw_clr) | rise;
    pend_held  = |(pend_sw & id_oh);
    ack_go     = (state_q == REQ) && pend_held && CPU_IRQ_ACK;
    ack_clr    = ack_go ? id_oh : '0;
    pending_d  = (pending_q & ~(sw_clr | ack_clr)) | rise;
    mask_d     = (wr_hit && ofs[1:0] == REG_MASK) ? BUS_DATA : mask_q;
    vld_d      = enc_vld;
  end

  // IDLE waits for a winner that has been eligible for a full cycle, which
  // gives the two-edge request latency and the idle gap between requests.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (vld_q && enc_vld) begin
          state_d = REQ;
          id_d    = enc_idx;
        end
      end
      REQ: begin
        if (!pend_held)   state_d = IDLE;
        else if (ack_go)  state_d = ACK;
        else if (timeout) state_d = IDLE;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef IRQ_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(p_ack_timeout + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_flag_q, tmo_flag_d;

  always_comb begin
    cnt_d      = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    timeout    = (state_q == REQ) && (cnt_q == CNT_W'(p_ack_timeout - 1));
    tmo_flag_d = tmo_flag_q;
    if (wr_hit && ofs[1:0] == REG_CLEAR && BUS_DATA[7]) tmo_flag_d = 1'b0;
    if (timeout && pend_held && !ack_go)                tmo_flag_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign tmo_flag = tmo_flag_q;
`else
  // The timeout length has no effect without the watchdog.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^p_ack_timeout;
  assign timeout        = 1'b0;
  assign tmo_flag       = 1'b0;
`endif

  always_comb begin
    rd_en_d   = rd_hit;
    rd_data_d = '0;
    case (ofs[1:0])
      REG_PENDING: rd_data_d[N-1:0] = pending_q;
      REG_MASK:    rd_data_d        = mask_q;
      REG_ACTIVE:  rd_data_d        = {tmo_flag, CPU_IRQ, 3'b000, id_q};
      default:     rd_data_d        = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      id_q       <= '0;
      pending_q  <= '0;
      mask_q     <= p_initial_mask;
      src_prev_q <= '0;
      vld_q      <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      src_prev_q <= src_prev_d;
      vld_q      <= vld_d;
      rd_en_q    <= rd_en_d;
    end
  end

  // Read data is only observed while rd_en_q drives the bus.
  always_ff @(posedge CLK) begin
    rd_data_q <= rd_data_d;
  end

  assign BUS_DATA    = rd_en_q ? rd_data_q : 8'bz;
  assign CPU_IRQ     = (state_q == REQ);
  assign CPU_IRQ_ID  = id_q;
  assign SRC_IRQ_ACK = (state_q == ACK) ? id_oh : '0;

endmodule
